// File: rtl/cpu_front_panel.sv
// Operator panel for the 16-bit CPU: synchronises and debounces the push-buttons,
// latches operands and opcode from the slide switches and drives the 7-segment bank.
module cpu_front_panel #(
    parameter int DATA_W     = 16,
    parameter int SW_W       = 10,
    parameter int OP_W       = 8,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW_W-1:0]       sw,
    input  logic                  a_btn_n,
    input  logic                  b_btn_n,
    input  logic                  op_btn_n,
    input  logic                  cin_btn_n,
    input  logic                  mode_btn_n,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [4:0]            flags,
    output logic [DATA_W-1:0]     a_out,
    output logic [DATA_W-1:0]     b_out,
    output logic [OP_W-1:0]       op_out,
    output logic                  cin,
    output logic                  load_strobe,
    output logic [1:0]            mode,
    output logic [DIGITS*7-1:0]   hex
);

    // Buttons that generate press events sit in the low indices; carry-in is level-only.
    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_OP   = 2;
    localparam int BTN_MODE = 3;
    localparam int BTN_CIN  = 4;
    localparam int NBTN     = 5;
    localparam int NEV      = 4;

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam int OPF_W = OP_W + 8;
    localparam int SRC_W = (DATA_W > OPF_W) ? DATA_W : OPF_W;
    localparam int PAD_W = (SRC_W > 4 * DIGITS) ? SRC_W : 4 * DIGITS;

    typedef enum logic [1:0] {
        MODE_ALU = 2'd0,
        MODE_A   = 2'd1,
        MODE_B   = 2'd2,
        MODE_OPF = 2'd3
    } mode_e;

    logic [NBTN-1:0]     w_btn_raw;
    logic [NBTN-1:0]     r_btn_sync1;
    logic [NBTN-1:0]     r_btn_sync2;
    logic [SW_W-1:0]     r_sw_sync1;
    logic [SW_W-1:0]     r_sw_sync2;
    logic [NBTN-1:0]     r_btn_stable;
    logic [CNT_W-1:0]    r_deb_cnt [NBTN];
    logic [NEV-1:0]      r_btn_stable_d;
    logic [NEV-1:0]      w_press;
    logic [DATA_W-1:0]   w_sw_data;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic                r_cin;
    logic                r_load_strobe;
    mode_e               r_mode;
    mode_e               w_mode_next;
    logic [PAD_W-1:0]    w_src;
    logic [DIGITS-1:0]   w_digit_on;
    logic [DIGITS*7-1:0] r_hex;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_btn_raw = {cin_btn_n, mode_btn_n, op_btn_n, b_btn_n, a_btn_n};

    // Two-stage synchronisers; buttons idle released (1), switches idle 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_sync1 <= '1;
            r_btn_sync2 <= '1;
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
        end else begin
            // NOTE: non-blocking so the second stage takes the first stage's previous value.
            r_btn_sync1 <= w_btn_raw;
            r_btn_sync2 <= r_btn_sync1;
            r_sw_sync1  <= sw;
            r_sw_sync2  <= r_sw_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_stable <= '1;
            // NOTE: the counter array is small state, not RAM, so it is reset like any register.
            for (int i = 0; i < NBTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (r_btn_sync2[i] == r_btn_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    r_deb_cnt[i]    <= '0;
                    r_btn_stable[i] <= ~r_btn_stable[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_stable_d <= '1;
        end else begin
            r_btn_stable_d <= r_btn_stable[NEV-1:0];
        end
    end

    assign w_press = r_btn_stable_d & ~r_btn_stable[NEV-1:0];

    if (SW_W >= DATA_W) begin : g_sw_trunc
        assign w_sw_data = r_sw_sync2[DATA_W-1:0];
    end else begin : g_sw_ext
        assign w_sw_data = {{(DATA_W - SW_W){1'b0}}, r_sw_sync2};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_cin         <= 1'b0;
            r_load_strobe <= 1'b0;
        end else begin
            if (w_press[BTN_A]) begin
                r_a <= w_sw_data;
            end
            if (w_press[BTN_B]) begin
                r_b <= w_sw_data;
            end
            if (w_press[BTN_OP]) begin
                r_op <= r_sw_sync2[OP_W-1:0];
            end
            r_load_strobe <= w_press[BTN_A] | w_press[BTN_B] | w_press[BTN_OP];
            r_cin         <= ~r_btn_stable[BTN_CIN];
        end
    end

    // Display-mode FSM: state register, next state, outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= MODE_ALU;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_mode_next = r_mode;
        if (w_press[BTN_MODE]) begin
            case (r_mode)
                MODE_ALU: w_mode_next = MODE_A;
                MODE_A:   w_mode_next = MODE_B;
                MODE_B:   w_mode_next = MODE_OPF;
                default:  w_mode_next = MODE_ALU;
            endcase
        end
    end

    always_comb begin
        w_src      = '0;
        w_digit_on = '0;
        case (r_mode)
            MODE_ALU: w_src[DATA_W-1:0] = alu_out;
            MODE_A:   w_src[DATA_W-1:0] = r_a;
            MODE_B:   w_src[DATA_W-1:0] = r_b;
            default:  w_src[OPF_W-1:0]  = {r_op, 3'b000, flags};
        endcase
        // Digits whose nibble lies wholly beyond the source width stay dark.
        for (int k = 0; k < DIGITS; k++) begin
            w_digit_on[k] = (r_mode == MODE_OPF) ? (4 * k < OPF_W) : (4 * k < DATA_W);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hex <= '1;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                r_hex[7*k +: 7] <= w_digit_on[k] ? f_glyph(w_src[4*k +: 4]) : 7'h7F;
            end
        end
    end

    assign a_out       = r_a;
    assign b_out       = r_b;
    assign op_out      = r_op;
    assign cin         = r_cin;
    assign load_strobe = r_load_strobe;
    assign mode        = r_mode;
    assign hex         = r_hex;

endmodule

// File: tb/tb_cpu_front_panel.sv
// Scoreboard bench for cpu_front_panel: stimulus queues expected latch/mode/carry events,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_cpu_front_panel;

    localparam int DATA_W = 16;
    localparam int SW_W   = 10;
    localparam int OP_W   = 8;
    localparam int DIGITS = 6;
    localparam int DEB    = 4;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        int                cyc;
    } lat_exp_t;

    typedef struct {
        logic [1:0] val;
        int         cyc;
    } mode_exp_t;

    typedef struct {
        logic val;
        int   cyc;
    } cin_exp_t;

    logic                 clk        = 1'b0;
    logic                 reset      = 1'b0;
    logic [SW_W-1:0]      sw         = '0;
    logic                 a_btn_n    = 1'b1;
    logic                 b_btn_n    = 1'b1;
    logic                 op_btn_n   = 1'b1;
    logic                 cin_btn_n  = 1'b1;
    logic                 mode_btn_n = 1'b1;
    logic [DATA_W-1:0]    alu_out    = 16'h1234;
    logic [4:0]           flags      = 5'h13;
    logic [DATA_W-1:0]    a_out;
    logic [DATA_W-1:0]    b_out;
    logic [OP_W-1:0]      op_out;
    logic                 cin;
    logic                 load_strobe;
    logic [1:0]           mode;
    logic [DIGITS*7-1:0]  hex;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    lat_exp_t  lat_q[$];
    mode_exp_t mode_q[$];
    cin_exp_t  cin_q[$];

    logic [DATA_W-1:0] m_a    = '0;
    logic [DATA_W-1:0] m_b    = '0;
    logic [OP_W-1:0]   m_op   = '0;
    logic [1:0]        m_mode = '0;

    cpu_front_panel #(
        .DATA_W    (DATA_W),
        .SW_W      (SW_W),
        .OP_W      (OP_W),
        .DIGITS    (DIGITS),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .a_btn_n    (a_btn_n),
        .b_btn_n    (b_btn_n),
        .op_btn_n   (op_btn_n),
        .cin_btn_n  (cin_btn_n),
        .mode_btn_n (mode_btn_n),
        .alu_out    (alu_out),
        .flags      (flags),
        .a_out      (a_out),
        .b_out      (b_out),
        .op_out     (op_out),
        .cin        (cin),
        .load_strobe(load_strobe),
        .mode       (mode),
        .hex        (hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    logic     prev_strobe = 1'b0;
    logic [1:0] prev_mode = 2'd0;
    logic     prev_cin    = 1'b0;

    always @(negedge clk) begin
        lat_exp_t  le;
        mode_exp_t me;
        cin_exp_t  ce;
        if (!reset) begin
            prev_strobe <= 1'b0;
            prev_mode   <= 2'd0;
            prev_cin    <= 1'b0;
        end else begin
            if (load_strobe) begin
                check("strobe_single_cycle", 64'(prev_strobe), 64'd0);
                if (lat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_expected: got load_strobe at cycle %0d, required none", cyc);
                end else begin
                    le = lat_q.pop_front();
                    check("latch_a_out",  64'(a_out),  64'(le.a));
                    check("latch_b_out",  64'(b_out),  64'(le.b));
                    check("latch_op_out", 64'(op_out), 64'(le.op));
                    check("latch_cycle",  64'(cyc),    64'(le.cyc));
                end
            end
            if (mode != prev_mode) begin
                if (mode_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mode_expected: got mode change to %0d at cycle %0d, required none", mode, cyc);
                end else begin
                    me = mode_q.pop_front();
                    check("mode_value", 64'(mode), 64'(me.val));
                    check("mode_cycle", 64'(cyc),  64'(me.cyc));
                end
            end
            if (cin != prev_cin) begin
                if (cin_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cin_expected: got cin change to %0d at cycle %0d, required none", cin, cyc);
                end else begin
                    ce = cin_q.pop_front();
                    check("cin_value", 64'(cin), 64'(ce.val));
                    check("cin_cycle", 64'(cyc), 64'(ce.cyc));
                end
            end
            prev_strobe <= load_strobe;
            prev_mode   <= mode;
            prev_cin    <= cin;
        end
    end

    // Inputs change 1 time unit after the falling edge so the monitor never races them.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // mask bits: 0 A, 1 B, 2 Op, 3 Cin, 4 Mode
    task automatic press(input logic [4:0] mask, input logic [SW_W-1:0] swv, input int hold);
        int n;
        sw = swv;
        n  = cyc;
        if (mask[0]) a_btn_n    = 1'b0;
        if (mask[1]) b_btn_n    = 1'b0;
        if (mask[2]) op_btn_n   = 1'b0;
        if (mask[3]) cin_btn_n  = 1'b0;
        if (mask[4]) mode_btn_n = 1'b0;
        if (mask[2:0] != 3'b000) begin
            if (mask[0]) m_a = DATA_W'(swv);
            if (mask[1]) m_b = DATA_W'(swv);
            if (mask[2]) m_op = swv[OP_W-1:0];
            lat_q.push_back('{m_a, m_b, m_op, n + 2 + DEB + 1});
        end
        if (mask[4]) begin
            m_mode = m_mode + 2'd1;
            mode_q.push_back('{m_mode, n + 2 + DEB + 1});
        end
        if (mask[3]) cin_q.push_back('{1'b1, n + 2 + DEB + 1});
        tick(hold);
        n = cyc;
        a_btn_n    = 1'b1;
        b_btn_n    = 1'b1;
        op_btn_n   = 1'b1;
        cin_btn_n  = 1'b1;
        mode_btn_n = 1'b1;
        if (mask[3]) cin_q.push_back('{1'b0, n + 2 + DEB + 1});
        tick(10);
    endtask

    localparam logic [41:0] HEX_ALU_1234 = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [41:0] HEX_A_02A5   = {7'h7F, 7'h7F, 7'h40, 7'h24, 7'h08, 7'h12};
    localparam logic [41:0] HEX_B_015A   = {7'h7F, 7'h7F, 7'h40, 7'h79, 7'h12, 7'h08};
    localparam logic [41:0] HEX_OPF_0013 = {7'h7F, 7'h7F, 7'h40, 7'h40, 7'h79, 7'h30};
    localparam logic [41:0] HEX_A_03FF   = {7'h7F, 7'h7F, 7'h40, 7'h30, 7'h0E, 7'h0E};

    initial begin
        int n;

        // Reset values
        tick(3);
        check("rst_a_out",       64'(a_out),       64'd0);
        check("rst_b_out",       64'(b_out),       64'd0);
        check("rst_op_out",      64'(op_out),      64'd0);
        check("rst_cin",         64'(cin),         64'd0);
        check("rst_load_strobe", 64'(load_strobe), 64'd0);
        check("rst_mode",        64'(mode),        64'd0);
        check("rst_hex",         64'(hex),         64'h3FF_FFFF_FFFF);
        reset = 1'b1;
        tick(1);
        check("post_rst_hex_alu", 64'(hex), 64'(HEX_ALU_1234));

        // Latch A, reset while still held, then the held button is re-accepted
        sw      = 10'h1F0;
        n       = cyc;
        a_btn_n = 1'b0;
        m_a     = 16'h01F0;
        lat_q.push_back('{m_a, m_b, m_op, n + 7});
        tick(12);
        check("pre_rst_a_out", 64'(a_out), 64'h01F0);
        reset = 1'b0;
        #1;
        check("mid_rst_a_out", 64'(a_out), 64'd0);
        check("mid_rst_mode",  64'(mode),  64'd0);
        check("mid_rst_hex",   64'(hex),   64'h3FF_FFFF_FFFF);
        m_a = '0;
        tick(2);
        reset = 1'b1;
        n     = cyc;
        m_a   = 16'h01F0;
        lat_q.push_back('{m_a, m_b, m_op, n + 7});
        tick(12);
        a_btn_n = 1'b1;
        tick(10);

        // A latch, held 20 cycles: single strobe
        press(5'b00001, 10'h2A5, 20);
        check("a_out_2a5", 64'(a_out), 64'h02A5);

        // Bouncing B is rejected, then a clean hold latches once
        sw = 10'h15A;
        for (int i = 0; i < 3; i++) begin
            b_btn_n = 1'b0;
            tick(2);
            b_btn_n = 1'b1;
            tick(2);
        end
        tick(8);
        check("b_after_bounce", 64'(b_out), 64'(m_b));
        press(5'b00010, 10'h15A, 10);
        check("b_out_15a", 64'(b_out), 64'h015A);

        // Mode cycling and display contents
        press(5'b10000, sw, 8);
        check("hex_mode1_a",   64'(hex), 64'(HEX_A_02A5));
        press(5'b10000, sw, 8);
        check("hex_mode2_b",   64'(hex), 64'(HEX_B_015A));
        press(5'b10000, sw, 8);
        check("hex_mode3_opf", 64'(hex), 64'(HEX_OPF_0013));
        press(5'b10000, sw, 8);
        check("hex_mode0_alu", 64'(hex), 64'(HEX_ALU_1234));
        press(5'b10000, sw, 8);
        check("hex_mode1_again", 64'(hex), 64'(HEX_A_02A5));
        check("mode_after_five", 64'(mode), 64'(m_mode));

        // Simultaneous A and B presses: one strobe
        press(5'b00011, 10'h3FF, 10);
        check("a_out_3ff", 64'(a_out), 64'h03FF);
        check("b_out_3ff", 64'(b_out), 64'h03FF);
        check("hex_a_3ff", 64'(hex),   64'(HEX_A_03FF));

        // Carry-in level, then opcode latch
        press(5'b01000, sw, 10);
        check("cin_released", 64'(cin), 64'd0);
        press(5'b00100, 10'h0C3, 10);
        check("op_out_c3", 64'(op_out), 64'hC3);

        tick(5);
        check("lat_q_drained",  64'(lat_q.size()),  64'd0);
        check("mode_q_drained", 64'(mode_q.size()), 64'd0);
        check("cin_q_drained",  64'(cin_q.size()),  64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
